// File: rtl/countdown_sequencer_pkg.sv
// Shared definitions for the countdown clock sequencer: state encoding,
// BCD constants and the BCD digit helpers used by the sequencer and its decrementer.
package countdown_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_00 = 8'h00;
  localparam int ALARM_CNT_W = 4;

  // Two-digit BCD check; max_tens limits the upper digit (5 for seconds).
  function automatic logic bcd_valid(input logic [7:0] v, input logic [3:0] max_tens);
    return (v[7:4] <= max_tens) && (v[3:0] <= 4'd9);
  endfunction

  // Two-digit BCD minus one; 00 wraps to 99.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) begin
      return {((v[7:4] == 4'd0) ? 4'd9 : v[7:4] - 4'd1), 4'd9};
    end
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/countdown_sequencer_bcd_mmss_dec.sv
// Combinational mm:ss BCD decrement by one second; zero flags a 00:00 result.
module bcd_mmss_dec
  import countdown_sequencer_pkg::*;
(
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       zero
);

  always_comb begin
    if (sec_in != BCD_00) begin
      min_out = min_in;
      sec_out = bcd_dec(sec_in);
    end else begin
      min_out = bcd_dec(min_in);
      sec_out = BCD_59;
    end
    zero = (min_out == BCD_00) && (sec_out == BCD_00);
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Run/pause/load controller for the mm:ss countdown clock. Counts down on falling
// edges of the 1 Hz divider output and restarts the divider on every entry into RUN.
module countdown_sequencer
  import countdown_sequencer_pkg::*;
#(
  parameter logic [7:0] DEF_MIN     = 8'h05,
  parameter logic [7:0] DEF_SEC     = 8'h00,
  parameter int         ALARM_TICKS = 5
) (
  input  logic       clk_50MHz,
  input  logic       set_n,
  input  logic       clk_1Hz,
  output logic       div_clear,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm,
  output logic       load_err,
  output logic [1:0] state_dbg
);

  localparam logic [ALARM_CNT_W-1:0] ALARM_LAST = ALARM_CNT_W'(ALARM_TICKS);

  state_t                 state_q, state_d;
  logic [7:0]             min_d, sec_d;
  logic                   alarm_d, load_err_d, div_clear_d;
  logic                   clr_d1_q, hist_q, hist_d;
  logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d, alarm_cnt_inc;
  logic [7:0]             dec_min, dec_sec;
  logic                   dec_zero, guard, tick, time_zero, load_ok;

  bcd_mmss_dec u_dec (
    .min_in  (min_bcd),
    .sec_in  (sec_bcd),
    .min_out (dec_min),
    .sec_out (dec_sec),
    .zero    (dec_zero)
  );

  // The divider output collapses to 0 while it is being cleared, so history is
  // held at 0 for the clear cycle and the one after to avoid a false tick.
  assign guard         = div_clear | clr_d1_q;
  assign tick          = !guard && hist_q && !clk_1Hz;
  assign hist_d        = guard ? 1'b0 : clk_1Hz;
  assign time_zero     = (min_bcd == BCD_00) && (sec_bcd == BCD_00);
  assign load_ok       = bcd_valid(load_min, 4'd9) && bcd_valid(load_sec, 4'd5);
  assign alarm_cnt_inc = alarm_cnt_q + ALARM_CNT_W'(1);
  assign state_dbg     = state_q;

  always_comb begin
    state_d     = state_q;
    min_d       = min_bcd;
    sec_d       = sec_bcd;
    alarm_d     = alarm;
    alarm_cnt_d = alarm_cnt_q;
    load_err_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (tick) begin
          min_d = dec_min;
          sec_d = dec_sec;
          if (dec_zero) begin
            state_d     = ST_DONE;
            alarm_d     = 1'b1;
            alarm_cnt_d = '0;
          end else if (pause) begin
            state_d = ST_PAUSE;
          end
        end else if (pause) begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        if (state_q == ST_DONE && tick && alarm) begin
          alarm_cnt_d = alarm_cnt_inc;
          if (alarm_cnt_inc == ALARM_LAST) alarm_d = 1'b0;
        end
        if (load) begin
          if (load_ok) begin
            state_d     = ST_IDLE;
            min_d       = load_min;
            sec_d       = load_sec;
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (start && !pause && state_q != ST_DONE && !time_zero) begin
          state_d = ST_RUN;
        end
      end
    endcase
    div_clear_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  always_ff @(posedge clk_50MHz) begin
    if (set_n) begin
      state_q     <= ST_IDLE;
      min_bcd     <= DEF_MIN;
      sec_bcd     <= DEF_SEC;
      running     <= 1'b0;
      done        <= 1'b0;
      alarm       <= 1'b0;
      load_err    <= 1'b0;
      div_clear   <= 1'b0;
      clr_d1_q    <= 1'b0;
      hist_q      <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      min_bcd     <= min_d;
      sec_bcd     <= sec_d;
      running     <= (state_d == ST_RUN);
      done        <= (state_d == ST_DONE);
      alarm       <= alarm_d;
      load_err    <= load_err_d;
      div_clear   <= div_clear_d;
      clr_d1_q    <= div_clear;
      hist_q      <= hist_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios plus random stimulus, checked
// every cycle against a model that keeps the time as a plain count of seconds.
module tb_countdown_sequencer;

  localparam int ALARM_TICKS = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk_50MHz = 1'b0;
  logic       set_n, clk_1Hz, start, pause, load;
  logic [7:0] load_min, load_sec;
  logic       div_clear, running, done, alarm, load_err;
  logic [7:0] min_bcd, sec_bcd;
  logic [1:0] state_dbg;

  countdown_sequencer #(
    .DEF_MIN     (8'h05),
    .DEF_SEC     (8'h00),
    .ALARM_TICKS (ALARM_TICKS)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .set_n     (set_n),
    .clk_1Hz   (clk_1Hz),
    .div_clear (div_clear),
    .start     (start),
    .pause     (pause),
    .load      (load),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .running   (running),
    .done      (done),
    .alarm     (alarm),
    .load_err  (load_err),
    .state_dbg (state_dbg)
  );

  // clock/reset
  always #10 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int from_bcd(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  // behavioural model: time as total seconds
  int  m_secs, m_mode, m_hist, m_age, m_alarm_ticks;
  bit  e_load_err, e_div_clear;

  always @(posedge clk_50MHz) begin
    int  prev_mode;
    bit  tick, ok;
    if (set_n) begin
      m_secs = 5 * 60; m_mode = M_IDLE; m_hist = 0; m_age = 2;
      m_alarm_ticks = 0; e_load_err = 0; e_div_clear = 0;
    end else begin
      tick = (m_age >= 2) && (m_hist == 1) && (clk_1Hz == 1'b0);
      m_hist = (m_age >= 2) ? int'(clk_1Hz) : 0;
      prev_mode = m_mode;
      e_load_err = 0;
      ok = (load_min[7:4] <= 9) && (load_min[3:0] <= 9) &&
           (load_sec[7:4] <= 5) && (load_sec[3:0] <= 9);
      if (m_mode == M_RUN) begin
        if (tick) begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            m_mode = M_DONE; m_alarm_ticks = 0;
          end else if (pause) m_mode = M_PAUSE;
        end else if (pause) m_mode = M_PAUSE;
      end else begin
        if (m_mode == M_DONE && tick) m_alarm_ticks++;
        if (load) begin
          if (ok) begin
            m_secs = from_bcd(load_min) * 60 + from_bcd(load_sec);
            m_mode = M_IDLE;
          end else e_load_err = 1;
        end else if (start && !pause && m_mode != M_DONE && m_secs != 0) m_mode = M_RUN;
      end
      e_div_clear = (m_mode == M_RUN) && (prev_mode != M_RUN);
      m_age = e_div_clear ? 0 : ((m_age < 2) ? m_age + 1 : 2);
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk_50MHz) begin
    if (chk_en) begin
      cmp("min_bcd",   min_bcd,   to_bcd(m_secs / 60));
      cmp("sec_bcd",   sec_bcd,   to_bcd(m_secs % 60));
      cmp("running",   {7'd0, running},   {7'd0, m_mode == M_RUN});
      cmp("done",      {7'd0, done},      {7'd0, m_mode == M_DONE});
      cmp("alarm",     {7'd0, alarm},     {7'd0, (m_mode == M_DONE) && (m_alarm_ticks < ALARM_TICKS)});
      cmp("load_err",  {7'd0, load_err},  {7'd0, e_load_err});
      cmp("div_clear", {7'd0, div_clear}, {7'd0, e_div_clear});
      cmp("state_dbg", {6'd0, state_dbg}, 8'(m_mode));
    end
  end

  // driver tasks: called at a negedge, return at a negedge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; load_min = m; load_sec = s;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1; cyc(1); pause = 1'b0;
  endtask

  task automatic fall();
    clk_1Hz = 1'b1; cyc(3);
    clk_1Hz = 1'b0; cyc(1);
  endtask

  initial begin
    int hz_cnt;
    set_n = 1'b1; clk_1Hz = 1'b0; start = 1'b0; pause = 1'b0; load = 1'b0;
    load_min = 8'h00; load_sec = 8'h00;
    cyc(3);
    set_n = 1'b0;
    chk_en = 1'b1;
    cyc(1);

    // reset defaults; a 1 Hz edge in IDLE changes nothing
    cmp("t1_min", min_bcd, 8'h05);
    cmp("t1_sec", sec_bcd, 8'h00);
    cmp("t1_flags", {4'd0, running, done, alarm, load_err}, 8'h00);
    fall();
    cmp("t1_idle_tick", sec_bcd, 8'h00);

    // run from 00:12; an edge inside the clear window is ignored
    do_load(8'h00, 8'h12);
    clk_1Hz = 1'b1; cyc(2);
    do_start();
    cmp("t2_div_clear", {7'd0, div_clear}, 8'h01);
    clk_1Hz = 1'b0; cyc(2);
    cmp("t2_guard", sec_bcd, 8'h12);
    fall(); cmp("t2_sec11", sec_bcd, 8'h11);
    fall(); cmp("t2_sec10", sec_bcd, 8'h10);
    fall(); cmp("t2_sec09", sec_bcd, 8'h09);

    // borrow across minutes
    do_pause();
    do_load(8'h01, 8'h00); do_start(); fall();
    cmp("t3_0059", {min_bcd, sec_bcd} == 16'h0059 ? 8'h01 : 8'h00, 8'h01);
    do_pause();
    do_load(8'h10, 8'h00); do_start(); fall();
    cmp("t3_0959_min", min_bcd, 8'h09);
    cmp("t3_0959_sec", sec_bcd, 8'h59);
    do_pause();

    // terminal count and alarm window
    do_load(8'h00, 8'h02); do_start(); fall(); fall();
    cmp("t4_done", {4'd0, running, done, alarm, load_err}, 8'h06);
    cmp("t4_zero", sec_bcd, 8'h00);
    for (int i = 0; i < 4; i++) fall();
    cmp("t4_alarm_held", {7'd0, alarm}, 8'h01);
    fall();
    cmp("t4_alarm_drop", {7'd0, alarm}, 8'h00);
    do_start();
    cmp("t4_start_ign", {6'd0, running, done}, 8'h01);
    do_load(8'h00, 8'h30);
    cmp("t4_load_clr", {6'd0, done, alarm}, 8'h00);
    cmp("t4_sec30", sec_bcd, 8'h30);

    // tick coinciding with pause
    do_load(8'h00, 8'h40); do_start();
    clk_1Hz = 1'b1; cyc(3);
    clk_1Hz = 1'b0; pause = 1'b1; cyc(1); pause = 1'b0;
    cmp("t5_sec39", sec_bcd, 8'h39);
    cmp("t5_paused", {7'd0, running}, 8'h00);
    fall(); fall(); fall();
    cmp("t5_frozen", sec_bcd, 8'h39);
    do_start();
    cmp("t5_reclear", {6'd0, div_clear, running}, 8'h03);

    // rejected and ignored loads
    do_pause();
    do_load(8'h00, 8'h75);
    cmp("t6_err_75", {7'd0, load_err}, 8'h01);
    cmp("t6_keep_sec", sec_bcd, 8'h39);
    cyc(1);
    cmp("t6_err_pulse", {7'd0, load_err}, 8'h00);
    do_load(8'h0A, 8'h00);
    cmp("t6_err_0a", {7'd0, load_err}, 8'h01);
    cmp("t6_keep_min", min_bcd, 8'h00);
    do_start(); cyc(2);
    do_load(8'h00, 8'h10);
    cmp("t6_run_noerr", {7'd0, load_err}, 8'h00);
    cmp("t6_run_keep", sec_bcd, 8'h39);

    // random stimulus
    hz_cnt = 3;
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      pause = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 19) == 0);
      set_n = ($urandom_range(0, 799) == 0);
      load_min = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      load_sec = ($urandom_range(0, 5) == 0) ? 8'($urandom)
               : {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      hz_cnt--;
      if (hz_cnt == 0) begin
        clk_1Hz = ~clk_1Hz;
        hz_cnt = $urandom_range(1, 6);
      end
      cyc(1);
    end
    start = 1'b0; pause = 1'b0; load = 1'b0; set_n = 1'b0;
    cyc(4);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
